// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - shared constants, funct3 codes and FSM states for the EX mul/div unit
package ex_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX,
    MD_DONE
  } md_state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - request/response bundle between ID/EX and the mul/div unit
interface ex_muldiv_unit_if;
  import ex_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in, flush,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in, flush,
    output stall, done, result, rd_out
  );

endinterface

// File: rtl/ex_muldiv_unit_step.sv
// rtl/ex_muldiv_unit_step.sv - one shift-add multiply or restoring-divide iteration
module muldiv_step
  import ex_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_new;

  // acc is {hi, lo}: product/multiplier for MUL, remainder/dividend-quotient for DIV
  always_comb begin
    mul_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + ({1'b0, opnd} & {(XLEN+1){acc_in[0]}});
    rem_sh  = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
    fits    = (rem_sh >= {1'b0, opnd});
    rem_new = fits ? (rem_sh[XLEN-1:0] - opnd) : rem_sh[XLEN-1:0];
    if (is_div) begin
      acc_out = {rem_new, acc_in[XLEN-2:0], fits};
    end else begin
      acc_out = {mul_sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV64M multiply/divide unit with pipeline stall request
module ex_muldiv_unit
  import ex_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ex_muldiv_unit_if.slave bus
);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_res_q, neg_res_d;
  logic              a_neg_q, a_neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic              is_div_op, div_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs, special_res;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   prod_sel, div_sel;

  muldiv_step u_step (
    .is_div  (state_q == MD_DIV),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (acc_step)
  );

  // Operand decode for the request currently offered by ID/EX
  always_comb begin
    a_signed  = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) && (bus.funct3 != F3_REMU);
    b_signed  = a_signed && (bus.funct3 != F3_MULHSU);
    a_neg     = a_signed & bus.rs1_val[XLEN-1];
    b_neg     = b_signed & bus.rs2_val[XLEN-1];
    a_abs     = neg_if(a_neg, bus.rs1_val);
    b_abs     = neg_if(b_neg, bus.rs2_val);
    is_div_op = bus.funct3[2];
    div_zero  = (bus.rs2_val == '0);
    div_ovf   = b_signed && is_div_op && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                && (bus.rs2_val == '1);
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.rs1_val : '1;
    end else begin
      special_res = bus.funct3[1] ? '0 : bus.rs1_val;
    end
  end

  // Sign fix-up of the magnitude result held in acc
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    prod_sel = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_sel  = f3_q[1] ? neg_if(a_neg_q, acc_q[2*XLEN-1:XLEN])
                       : neg_if(neg_res_q, acc_q[XLEN-1:0]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    neg_res_d = neg_res_q;
    a_neg_d   = a_neg_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    case (state_q)
      MD_IDLE: begin
        if (bus.start) begin
          f3_d      = bus.funct3;
          rd_d      = bus.rd_in;
          neg_res_d = a_neg ^ b_neg;
          a_neg_d   = a_neg;
          cnt_d     = '0;
          if (!is_div_op) begin
            acc_d   = {{XLEN{1'b0}}, b_abs};
            opnd_d  = a_abs;
            state_d = MD_MUL;
          end else if (div_zero || div_ovf) begin
            result_d = special_res;
            rd_out_d = bus.rd_in;
            state_d  = MD_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_abs};
            opnd_d  = b_abs;
            state_d = MD_DIV;
          end
        end
      end
      MD_MUL, MD_DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        result_d = f3_q[2] ? div_sel : prod_sel;
        rd_out_d = rd_q;
        state_d  = MD_DONE;
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase

    // A squash abandons the op without disturbing the last delivered result
    if (bus.flush) begin
      state_d  = MD_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      a_neg_q   <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      neg_res_q <= neg_res_d;
      a_neg_q   <= a_neg_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  // The IDLE term is combinational so ID/EX freezes in the start cycle itself
  assign bus.stall  = (state_q inside {MD_MUL, MD_DIV, MD_FIX})
                    | ((state_q == MD_IDLE) & bus.start & ~bus.flush);
  assign bus.done   = (state_q == MD_DONE) & ~bus.flush;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
